cpu_lsu: RTL and testbench



---
 rtl/cpu_lsu.sv | 149 ++++++++++++++
 tb/tb_cpu_lsu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_lsu.sv
// Load-store unit: turns core load/store requests into handshaked word-bus accesses,
// stalling the core until the bus answers or the access times out.
module cpu_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic [3:0]  r_be;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic        r_req;

  logic        w_idle;
  logic        w_wait;
  logic        w_illegal;
  logic        w_bad;
  logic        w_launch;

  function automatic logic [3:0] f_be(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   f_be = 4'b0001 << off;
      2'b01:   f_be = 4'b0011 << off;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] size, input logic [31:0] wd);
    case (size[1:0])
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  // size[2] selects zero extension (BU/HU).
  function automatic logic [31:0] f_extend(input logic [2:0] size, input logic [31:0] word,
                                           input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size[1:0])
      2'b00:   f_extend = {{24{sh[7] & ~size[2]}}, sh[7:0]};
      2'b01:   f_extend = {{16{sh[15] & ~size[2]}}, sh[15:0]};
      default: f_extend = sh;
    endcase
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign w_wait    = (r_state == S_WAIT);
  assign w_illegal = (size_i == 3'b011) || (size_i == 3'b110) || (size_i == 3'b111) ||
                     (size_i[2] && we_i);
  assign w_bad     = w_illegal || ((size_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((size_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  assign w_launch  = w_idle && req_i && !w_bad;

  assign misaligned_o = w_idle && req_i && w_bad;
  assign stall_o      = w_launch || w_wait;
  assign rdata_o      = r_rdata;
  assign fault_o      = r_fault;
  assign mem_req_o    = r_req;
  assign mem_we_o     = r_we;
  assign mem_be_o     = r_be;
  assign mem_addr_o   = {r_addr, 2'b00};
  assign mem_wdata_o  = r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= 3'b000;
      r_off   <= 2'b00;
      r_be    <= 4'b0000;
      r_addr  <= 30'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_we    <= we_i;
            r_size  <= size_i;
            r_off   <= addr_i[1:0];
            r_be    <= f_be(size_i, addr_i[1:0]);
            r_addr  <= addr_i[31:2];
            r_wdata <= f_wdata(size_i, wdata_i);
            r_cnt   <= 8'd0;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A ready arriving on the limit cycle still completes normally.
          if (mem_ready_i) begin
            r_req   <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_DONE;
            if (!r_we) r_rdata <= f_extend(r_size, mem_rdata_i, r_off);
          end else if (r_cnt == LIMIT) begin
            r_req   <= 1'b0;
            r_cnt   <= 8'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: loads, stores, rejected accesses, ready delay,
// reset during an access and bus timeout.
module tb_cpu_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  size_i = 3'b000;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_ready_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Observations captured by run_access.
  int          o_stall;
  int          o_waits;
  logic        o_held;
  logic        o_hung;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic        o_fault_after;
  logic        o_req_done;

  cpu_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .misaligned_o(misaligned_o), .fault_o(fault_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk = ~clk;

  // Drives one access; ready is raised on WAIT cycle index rdy (0 = first), never if rdy < 0.
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] bus, input int rdy);
    int guard;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wd;
    mem_rdata_i = bus; mem_ready_i = 1'b0;
    o_stall = 0; o_waits = 0; o_held = 1'b1; o_hung = 1'b0;
    #1;
    if (stall_o) o_stall++;
    @(posedge clk); #1;
    req_i = 1'b0;
    o_we = mem_we_o; o_be = mem_be_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o;
    guard = 0;
    while (stall_o && guard < 100) begin
      o_stall++;
      if (!mem_req_o || mem_we_o !== o_we || mem_be_o !== o_be ||
          mem_addr_o !== o_addr || mem_wdata_o !== o_wdata) o_held = 1'b0;
      mem_ready_i = (rdy >= 0) && (o_waits == rdy);
      @(posedge clk); #1;
      o_waits++;
      guard++;
    end
    if (guard >= 100) o_hung = 1'b1;
    mem_ready_i = 1'b0;
    o_rdata = rdata_o; o_fault = fault_o; o_req_done = mem_req_o;
    @(posedge clk); #1;
    o_fault_after = fault_o;
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({rdata_o, mem_req_o, fault_o, stall_o} !== 35'd0) begin
      n_err++; $display("FAIL reset_ctrl: rdata=%h req=%b fault=%b stall=%b, want 0", rdata_o, mem_req_o, fault_o, stall_o);
    end
    n_vec++;
    if ({mem_be_o, mem_addr_o, mem_wdata_o} !== 68'd0) begin
      n_err++; $display("FAIL reset_bus: be=%b addr=%h wdata=%h, want 0", mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_word_load;
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    n_vec++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
      n_err++; $display("FAIL lw_bus: addr=%h be=%b we=%b, want 00000100 1111 0", o_addr, o_be, o_we);
    end
    n_vec++;
    if (o_stall !== 2 || o_hung) begin
      n_err++; $display("FAIL lw_stall: stall cycles=%0d hung=%b, want 2", o_stall, o_hung);
    end
    n_vec++;
    if (o_rdata !== 32'hDEADBEEF || o_req_done !== 1'b0 || o_fault !== 1'b0) begin
      n_err++; $display("FAIL lw_data: rdata=%h req=%b fault=%b, want deadbeef 0 0", o_rdata, o_req_done, o_fault);
    end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  sz [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
    logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    logic [3:0]  be [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, sz[i], ad[i], 32'h0, 32'h80FF7F01, 0);
      n_vec++;
      if (o_rdata !== ex[i] || o_be !== be[i]) begin
        n_err++; $display("FAIL subload_%0d: rdata=%h be=%b, want %h %b", i, o_rdata, o_be, ex[i], be[i]);
      end
    end
  endtask

  task automatic test_stores;
    run_access(1'b1, 3'b000, 32'h301, 32'h12345678, 32'hFFFFFFFF, 0);
    n_vec++;
    if (o_be !== 4'b0010 || o_wdata !== 32'h78787878 || o_addr !== 32'h300 || o_we !== 1'b1) begin
      n_err++; $display("FAIL sb: be=%b wdata=%h addr=%h we=%b, want 0010 78787878 00000300 1", o_be, o_wdata, o_addr, o_we);
    end
    n_vec++;
    if (o_rdata !== 32'h00007F01) begin
      n_err++; $display("FAIL sb_rdata: rdata=%h, want 00007f01", o_rdata);
    end
    run_access(1'b1, 3'b001, 32'h302, 32'h12345678, 32'hFFFFFFFF, 0);
    n_vec++;
    if (o_be !== 4'b1100 || o_wdata !== 32'h56785678) begin
      n_err++; $display("FAIL sh: be=%b wdata=%h, want 1100 56785678", o_be, o_wdata);
    end
    n_vec++;
    if (o_rdata !== 32'h00007F01) begin
      n_err++; $display("FAIL sh_rdata: rdata=%h, want 00007f01", o_rdata);
    end
  endtask

  task automatic test_misaligned;
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  sz [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_i = 1'b1; we_i = we[i]; size_i = sz[i]; addr_i = ad[i]; mem_ready_i = 1'b1;
      #1;
      n_vec++;
      if (misaligned_o !== 1'b1 || stall_o !== 1'b0) begin
        n_err++; $display("FAIL misal_%0d: misaligned=%b stall=%b, want 1 0", i, misaligned_o, stall_o);
      end
      @(posedge clk); #1;
      n_vec++;
      if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h00007F01) begin
        n_err++; $display("FAIL misal_bus_%0d: req=%b stall=%b rdata=%h, want 0 0 00007f01", i, mem_req_o, stall_o, rdata_o);
      end
      req_i = 1'b0; mem_ready_i = 1'b0;
    end
  endtask

  task automatic test_ready_delay;
    // Ready arrives on the fifth WAIT cycle.
    run_access(1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 4);
    n_vec++;
    if (o_stall !== 6 || o_waits !== 5 || !o_held) begin
      n_err++; $display("FAIL delay_timing: stall=%0d waits=%0d held=%b, want 6 5 1", o_stall, o_waits, o_held);
    end
    n_vec++;
    if (o_rdata !== 32'hCAFEF00D || o_fault !== 1'b0) begin
      n_err++; $display("FAIL delay_data: rdata=%h fault=%b, want cafef00d 0", o_rdata, o_fault);
    end
  endtask

  task automatic test_reset_mid_access;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; size_i = 3'b010; addr_i = 32'h400;
    @(posedge clk); #1; req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: req=%b stall=%b, want 1 1", mem_req_o, stall_o);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0) begin
      n_err++; $display("FAIL rst_mid: req=%b stall=%b rdata=%h, want 0 0 0", mem_req_o, stall_o, rdata_o);
    end
    @(posedge clk); #1; reset = 1'b1;
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0);
    n_vec++;
    if (o_rdata !== 32'h0BADF00D || o_stall !== 2) begin
      n_err++; $display("FAIL rst_after: rdata=%h stall=%0d, want 0badf00d 2", o_rdata, o_stall);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 3'b010, 32'h600, 32'h0, 32'h55555555, -1);
    n_vec++;
    if (o_hung || o_waits !== 16 || o_stall !== 17) begin
      n_err++; $display("FAIL to_timing: waits=%0d stall=%0d hung=%b, want 16 17 0", o_waits, o_stall, o_hung);
    end
    n_vec++;
    if (o_fault !== 1'b1 || o_fault_after !== 1'b0 || o_rdata !== 32'h0 || o_req_done !== 1'b0) begin
      n_err++; $display("FAIL to_result: fault=%b next=%b rdata=%h req=%b, want 1 0 0 0", o_fault, o_fault_after, o_rdata, o_req_done);
    end
    n_vec++;
    if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++; $display("FAIL to_idle: stall=%b req=%b, want 0 0", stall_o, mem_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_stores();
    test_misaligned();
    test_ready_delay();
    test_reset_mid_access();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
